// File: rtl/fetch_sequencer_if.sv
// Fetch front-end bundle: memory read port, instruction issue port and PC redirect.
interface fetch_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 16
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OPER_W = 16;
    localparam int unsigned LEN_W  = 2;

    // Memory read port
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd_en;
    logic                  mem_rdy;
    logic [DATA_W-1:0]     mem_rd_data;

    // Instruction issue port
    logic                  inst_valid;
    logic                  inst_ready;
    logic [DATA_W-1:0]     inst_opcode;
    logic [OPER_W-1:0]     inst_operand;
    logic [LEN_W-1:0]      inst_len;
    logic [ADDR_WIDTH-1:0] inst_pc;

    // PC redirect from execute
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;

    modport master (
        output mem_addr,
        output mem_rd_en,
        input  mem_rdy,
        input  mem_rd_data,
        output inst_valid,
        input  inst_ready,
        output inst_opcode,
        output inst_operand,
        output inst_len,
        output inst_pc,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  mem_addr,
        input  mem_rd_en,
        output mem_rdy,
        output mem_rd_data,
        input  inst_valid,
        output inst_ready,
        input  inst_opcode,
        input  inst_operand,
        input  inst_len,
        input  inst_pc,
        output redirect_valid,
        output redirect_pc
    );

endinterface

// File: rtl/fetch_sequencer.sv
// 6502 instruction-fetch front end: vector load, opcode/operand fetch,
// internal JMP abs/ind resolution, issue over valid/ready, redirect from execute.
module fetch_sequencer #(
    parameter int unsigned           ADDR_WIDTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(16'hFFFC),
    parameter bit                    JMP_IND_BUG  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OPER_W = 16;
    localparam int unsigned LEN_W  = 2;
    localparam int unsigned ST_W   = 9;

    localparam logic [DATA_W-1:0] OP_JMP_ABS = 8'h4C;
    localparam logic [DATA_W-1:0] OP_JMP_IND = 8'h6C;

    typedef enum logic [ST_W-1:0] {
        ST_RST     = 9'b000000001,
        ST_VEC_LO  = 9'b000000010,
        ST_VEC_HI  = 9'b000000100,
        ST_OPCODE  = 9'b000001000,
        ST_OPER_LO = 9'b000010000,
        ST_OPER_HI = 9'b000100000,
        ST_IND_LO  = 9'b001000000,
        ST_IND_HI  = 9'b010000000,
        ST_ISSUE   = 9'b100000000
    } state_t;

    state_t                state_q,   state_d;
    logic [ADDR_WIDTH-1:0] pc_q,      pc_d;
    logic [DATA_W-1:0]     opc_q,     opc_d;
    logic [DATA_W-1:0]     lo_q,      lo_d;
    logic [DATA_W-1:0]     hi_q,      hi_d;
    logic [DATA_W-1:0]     tmp_q,     tmp_d;
    logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic [LEN_W-1:0]      len_q,     len_d;
    logic                  valid_q,   valid_d;

    logic [ADDR_WIDTH-1:0] mem_addr_c;
    logic                  mem_rd_en_c;
    logic [LEN_W-1:0]      new_len_c;
    logic [OPER_W-1:0]     ptr_c;
    logic [OPER_W-1:0]     ptr_next_c;
    logic                  redirect_ok_c;

    // Instruction length from the opcode byte (3-byte forms take priority)
    function automatic logic [LEN_W-1:0] decode_len(input logic [DATA_W-1:0] op);
        if (op[3:2] == 2'b11 || op[4:0] == 5'b11001 || op == 8'h20) begin
            return LEN_W'(3);
        end else if (op[3:0] == 4'h8 || op[3:0] == 4'hA ||
                     op == 8'h00 || op == 8'h40 || op == 8'h60) begin
            return LEN_W'(1);
        end else begin
            return LEN_W'(2);
        end
    endfunction

    // Indirect pointer and its successor; the 6502 bug wraps within the page
    always_comb begin
        ptr_c = {hi_q, lo_q};
        if (JMP_IND_BUG) begin
            ptr_next_c = {hi_q, lo_q + DATA_W'(1)};
        end else begin
            ptr_next_c = ptr_c + OPER_W'(1);
        end
    end

    // Next-state, datapath updates and memory request decode
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        opc_d         = opc_q;
        lo_d          = lo_q;
        hi_d          = hi_q;
        tmp_d         = tmp_q;
        inst_pc_d     = inst_pc_q;
        len_d         = len_q;
        mem_addr_c    = pc_q;
        mem_rd_en_c   = 1'b0;
        new_len_c     = decode_len(bus.mem_rd_data);
        redirect_ok_c = 1'b1;

        unique case (state_q)
            ST_RST: begin
                redirect_ok_c = 1'b0;
                state_d       = ST_VEC_LO;
            end
            ST_VEC_LO: begin
                redirect_ok_c = 1'b0;
                mem_rd_en_c   = 1'b1;
                mem_addr_c    = RESET_VECTOR;
                if (bus.mem_rdy) begin
                    pc_d[7:0] = bus.mem_rd_data;
                    state_d   = ST_VEC_HI;
                end
            end
            ST_VEC_HI: begin
                redirect_ok_c = 1'b0;
                mem_rd_en_c   = 1'b1;
                mem_addr_c    = RESET_VECTOR + ADDR_WIDTH'(1);
                if (bus.mem_rdy) begin
                    pc_d    = ADDR_WIDTH'({bus.mem_rd_data, pc_q[7:0]});
                    state_d = ST_OPCODE;
                end
            end
            ST_OPCODE: begin
                mem_rd_en_c = 1'b1;
                if (bus.mem_rdy) begin
                    opc_d     = bus.mem_rd_data;
                    inst_pc_d = pc_q;
                    len_d     = new_len_c;
                    lo_d      = '0;
                    hi_d      = '0;
                    pc_d      = pc_q + ADDR_WIDTH'(1);
                    state_d   = (new_len_c > LEN_W'(1)) ? ST_OPER_LO : ST_ISSUE;
                end
            end
            ST_OPER_LO: begin
                mem_rd_en_c = 1'b1;
                if (bus.mem_rdy) begin
                    lo_d    = bus.mem_rd_data;
                    pc_d    = pc_q + ADDR_WIDTH'(1);
                    state_d = (len_q == LEN_W'(3)) ? ST_OPER_HI : ST_ISSUE;
                end
            end
            ST_OPER_HI: begin
                mem_rd_en_c = 1'b1;
                if (bus.mem_rdy) begin
                    hi_d = bus.mem_rd_data;
                    pc_d = pc_q + ADDR_WIDTH'(1);
                    if (opc_q == OP_JMP_ABS) begin
                        pc_d    = ADDR_WIDTH'({bus.mem_rd_data, lo_q});
                        state_d = ST_OPCODE;
                    end else if (opc_q == OP_JMP_IND) begin
                        state_d = ST_IND_LO;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_IND_LO: begin
                mem_rd_en_c = 1'b1;
                mem_addr_c  = ADDR_WIDTH'(ptr_c);
                if (bus.mem_rdy) begin
                    tmp_d   = bus.mem_rd_data;
                    state_d = ST_IND_HI;
                end
            end
            ST_IND_HI: begin
                mem_rd_en_c = 1'b1;
                mem_addr_c  = ADDR_WIDTH'(ptr_next_c);
                if (bus.mem_rdy) begin
                    pc_d    = ADDR_WIDTH'({bus.mem_rd_data, tmp_q});
                    state_d = ST_OPCODE;
                end
            end
            ST_ISSUE: begin
                if (bus.inst_ready) begin
                    state_d = ST_OPCODE;
                end
            end
            default: begin
                redirect_ok_c = 1'b0;
                state_d       = ST_RST;
            end
        endcase

        // Redirect overrides any stall or pending issue once the vector is loaded
        if (bus.redirect_valid && redirect_ok_c) begin
            state_d = ST_OPCODE;
            pc_d    = bus.redirect_pc;
        end

        valid_d = (state_d == ST_ISSUE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RST;
            pc_q      <= '0;
            opc_q     <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            tmp_q     <= '0;
            inst_pc_q <= '0;
            len_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opc_q     <= opc_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            tmp_q     <= tmp_d;
            inst_pc_q <= inst_pc_d;
            len_q     <= len_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.mem_addr     = mem_addr_c;
    assign bus.mem_rd_en    = mem_rd_en_c;
    assign bus.inst_valid   = valid_q;
    assign bus.inst_opcode  = opc_q;
    assign bus.inst_operand = {hi_q, lo_q};
    assign bus.inst_len     = len_q;
    assign bus.inst_pc      = inst_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: two instances (page-wrap bug on/off)
// share one byte-wide memory and the same control stimulus.
module tb_fetch_sequencer;

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] oper;
        logic [1:0]  len;
        logic [15:0] pc;
    } inst_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_rdy;
    logic        inst_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [7:0]  mem [65536];

    int    n_checks = 0;
    int    n_pass   = 0;
    inst_t exp_q[$];

    fetch_sequencer_if #(.ADDR_WIDTH(16)) bus_a ();
    fetch_sequencer_if #(.ADDR_WIDTH(16)) bus_b ();

    assign bus_a.mem_rdy        = mem_rdy;
    assign bus_a.inst_ready     = inst_ready;
    assign bus_a.redirect_valid = redirect_valid;
    assign bus_a.redirect_pc    = redirect_pc;
    assign bus_a.mem_rd_data    = mem[bus_a.mem_addr];
    assign bus_b.mem_rdy        = mem_rdy;
    assign bus_b.inst_ready     = inst_ready;
    assign bus_b.redirect_valid = redirect_valid;
    assign bus_b.redirect_pc    = redirect_pc;
    assign bus_b.mem_rd_data    = mem[bus_b.mem_addr];

    fetch_sequencer #(.ADDR_WIDTH(16), .RESET_VECTOR(16'hFFFC), .JMP_IND_BUG(1'b1)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    fetch_sequencer #(.ADDR_WIDTH(16), .RESET_VECTOR(16'hFFFC), .JMP_IND_BUG(1'b0)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] op, input logic [15:0] oper,
                        input logic [1:0] len, input logic [15:0] pc);
        inst_t e;
        e.op = op; e.oper = oper; e.len = len; e.pc = pc;
        exp_q.push_back(e);
    endtask

    task automatic wr3(input logic [15:0] a, input logic [7:0] b0,
                       input logic [7:0] b1, input logic [7:0] b2);
        mem[a]               = b0;
        mem[a + 16'd1]       = b1;
        mem[a + 16'd2]       = b2;
    endtask

    // Wait (bounded) for every expected issue to be consumed
    task automatic drain(input string name);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Reset both DUTs and return in the first OPCODE cycle
    task automatic boot(input logic [15:0] vec);
        reset = 1'b1; mem_rdy = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0;
        mem[16'hFFFC] = vec[7:0];
        mem[16'hFFFD] = vec[15:8];
        step();
        reset = 1'b0;
        step(); step(); step();
    endtask

    // Scoreboard monitor: compare every accepted issue against the queue
    always @(negedge clk) begin
        if (!reset && bus_a.inst_valid && bus_a.inst_ready) begin
            if (exp_q.size() == 0) begin
                chk("issue_unexpected",
                    64'({bus_a.inst_opcode, bus_a.inst_operand, bus_a.inst_len, bus_a.inst_pc}),
                    64'h0);
            end else begin
                inst_t e;
                e = exp_q.pop_front();
                chk("issue",
                    64'({bus_a.inst_opcode, bus_a.inst_operand, bus_a.inst_len, bus_a.inst_pc}),
                    64'(e));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; mem_rdy = 1'b1; inst_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        // T1/T2: vector load timing, then a NOP stream ending in a self-loop
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
        wr3(16'h8000, 8'hEA, 8'hEA, 8'hEA);
        wr3(16'h8003, 8'h4C, 8'h03, 8'h80);
        step(); step();
        chk("rst_valid", 64'(bus_a.inst_valid), 64'd0);
        chk("rst_rd_en", 64'(bus_a.mem_rd_en), 64'd0);
        chk("rst_outputs", 64'({bus_a.inst_opcode, bus_a.inst_operand, bus_a.inst_len, bus_a.inst_pc}), 64'd0);
        push(8'hEA, 16'h0000, 2'd1, 16'h8000);
        push(8'hEA, 16'h0000, 2'd1, 16'h8001);
        push(8'hEA, 16'h0000, 2'd1, 16'h8002);
        reset = 1'b0;
        chk("t1_rst_cycle_rd_en", 64'(bus_a.mem_rd_en), 64'd0);
        step();
        chk("t1_vec_lo_addr", 64'(bus_a.mem_addr), 64'hFFFC);
        chk("t1_vec_lo_rd_en", 64'(bus_a.mem_rd_en), 64'd1);
        step();
        chk("t1_vec_hi_addr", 64'(bus_a.mem_addr), 64'hFFFD);
        step();
        chk("t1_opcode_addr", 64'(bus_a.mem_addr), 64'h8000);
        for (int i = 0; i < 6; i++) begin
            chk("t2_valid_pattern", 64'(bus_a.inst_valid), 64'(i % 2));
            step();
        end
        drain("t2_drain");

        // T3: JMP abs resolved internally, three cycles to the target fetch
        wr3(16'h8000, 8'h4C, 8'h34, 8'h12);
        mem[16'h1234] = 8'hEA;
        wr3(16'h1235, 8'h4C, 8'h35, 8'h12);
        push(8'hEA, 16'h0000, 2'd1, 16'h1234);
        boot(16'h8000);
        chk("t3_c0_addr", 64'(bus_a.mem_addr), 64'h8000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_no_valid", 64'(bus_a.inst_valid), 64'd0);
        end
        chk("t3_target_addr", 64'(bus_a.mem_addr), 64'h1234);
        drain("t3_drain");

        // T4: JMP ind with and without the page-wrap bug
        wr3(16'h8000, 8'h6C, 8'hFF, 8'h02);
        mem[16'h02FF] = 8'h78; mem[16'h0200] = 8'h56; mem[16'h0300] = 8'h99;
        mem[16'h5678] = 8'hEA; wr3(16'h5679, 8'h4C, 8'h79, 8'h56);
        mem[16'h9978] = 8'hEA; wr3(16'h9979, 8'h4C, 8'h79, 8'h99);
        push(8'hEA, 16'h0000, 2'd1, 16'h5678);
        boot(16'h8000);
        step(); step(); step();
        chk("t4_ind_lo_a", 64'(bus_a.mem_addr), 64'h02FF);
        chk("t4_ind_lo_b", 64'(bus_b.mem_addr), 64'h02FF);
        step();
        chk("t4_ind_hi_a", 64'(bus_a.mem_addr), 64'h0200);
        chk("t4_ind_hi_b", 64'(bus_b.mem_addr), 64'h0300);
        step();
        chk("t4_target_a", 64'(bus_a.mem_addr), 64'h5678);
        chk("t4_target_b", 64'(bus_b.mem_addr), 64'h9978);
        chk("t4_no_valid", 64'(bus_a.inst_valid), 64'd0);
        drain("t4_drain");

        // T5: memory stall in OPER_HI, then back-pressure on the issue
        wr3(16'h8000, 8'hAD, 8'h00, 8'hC0);
        wr3(16'h8003, 8'h4C, 8'h03, 8'h80);
        push(8'hAD, 16'hC000, 2'd3, 16'h8000);
        boot(16'h8000);
        step();
        step();
        mem_rdy = 1'b0;
        chk("t5_stall_addr0", 64'(bus_a.mem_addr), 64'h8002);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t5_stall_addr", 64'(bus_a.mem_addr), 64'h8002);
            chk("t5_stall_no_valid", 64'(bus_a.inst_valid), 64'd0);
        end
        step();
        mem_rdy = 1'b1;
        chk("t5_release_addr", 64'(bus_a.mem_addr), 64'h8002);
        step();
        inst_ready = 1'b0;
        chk("t5_issue_valid", 64'(bus_a.inst_valid), 64'd1);
        chk("t5_issue_rd_en", 64'(bus_a.mem_rd_en), 64'd0);
        chk("t5_issue_fields", 64'({bus_a.inst_opcode, bus_a.inst_operand, bus_a.inst_len, bus_a.inst_pc}),
            64'({8'hAD, 16'hC000, 2'd3, 16'h8000}));
        step();
        chk("t5_hold_valid", 64'(bus_a.inst_valid), 64'd1);
        chk("t5_hold_fields", 64'({bus_a.inst_opcode, bus_a.inst_operand, bus_a.inst_len, bus_a.inst_pc}),
            64'({8'hAD, 16'hC000, 2'd3, 16'h8000}));
        step();
        inst_ready = 1'b1;
        step();
        chk("t5_after_accept_valid", 64'(bus_a.inst_valid), 64'd0);
        chk("t5_after_accept_addr", 64'(bus_a.mem_addr), 64'h8003);
        drain("t5_drain");

        // T6b: PC wrap FFFF -> 0000, redirect ignored while loading the vector
        mem[16'hFFFF] = 8'hA9;
        mem[16'h0000] = 8'h42;
        wr3(16'h0001, 8'h4C, 8'h01, 8'h00);
        mem[16'h4000] = 8'hEA;
        wr3(16'h4001, 8'h4C, 8'h01, 8'h40);
        push(8'hA9, 16'h0042, 2'd2, 16'hFFFF);
        reset = 1'b1; mem_rdy = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0;
        mem[16'hFFFC] = 8'hFF; mem[16'hFFFD] = 8'hFF;
        step();
        reset = 1'b0;
        step();
        redirect_valid = 1'b1; redirect_pc = 16'h4000;
        step();
        chk("t6_vec_redirect_ignored", 64'(bus_a.mem_addr), 64'hFFFD);
        step();
        redirect_valid = 1'b0;
        chk("t6_wrap_opcode_addr", 64'(bus_a.mem_addr), 64'hFFFF);
        step();
        chk("t6_wrap_operand_addr", 64'(bus_a.mem_addr), 64'h0000);
        drain("t6b_drain");

        // T6a: redirect in OPER_LO beats a memory stall and drops the instruction
        push(8'hEA, 16'h0000, 2'd1, 16'h4000);
        boot(16'hFFFF);
        step();
        chk("t6_oper_lo_addr", 64'(bus_a.mem_addr), 64'h0000);
        redirect_valid = 1'b1; redirect_pc = 16'h4000; mem_rdy = 1'b0;
        step();
        redirect_valid = 1'b0; mem_rdy = 1'b1;
        chk("t6_redirect_addr", 64'(bus_a.mem_addr), 64'h4000);
        chk("t6_redirect_no_valid", 64'(bus_a.inst_valid), 64'd0);
        drain("t6a_drain");

        // T7: redirect while an issue is stalled drops it
        wr3(16'h8000, 8'hA9, 8'h11, 8'h4C);
        wr3(16'h8003, 8'h03, 8'h80, 8'h00);
        push(8'hEA, 16'h0000, 2'd1, 16'h4000);
        boot(16'h8000);
        step();
        inst_ready = 1'b0;
        step();
        chk("t7_pending_valid", 64'(bus_a.inst_valid), 64'd1);
        redirect_valid = 1'b1; redirect_pc = 16'h4000;
        step();
        redirect_valid = 1'b0; inst_ready = 1'b1;
        chk("t7_dropped_valid", 64'(bus_a.inst_valid), 64'd0);
        chk("t7_redirect_addr", 64'(bus_a.mem_addr), 64'h4000);
        drain("t7_drain");

        // T8: redirect in the acceptance cycle keeps the issue
        mem[16'h8001] = 8'h22;
        push(8'hA9, 16'h0022, 2'd2, 16'h8000);
        push(8'hEA, 16'h0000, 2'd1, 16'h4000);
        boot(16'h8000);
        step();
        step();
        chk("t8_issue_valid", 64'(bus_a.inst_valid), 64'd1);
        redirect_valid = 1'b1; redirect_pc = 16'h4000;
        step();
        redirect_valid = 1'b0;
        chk("t8_redirect_addr", 64'(bus_a.mem_addr), 64'h4000);
        drain("t8_drain");

        // Mid-operation reset aborts with nothing issued
        wr3(16'h8000, 8'hAD, 8'h00, 8'hC0);
        boot(16'h8000);
        step();
        reset = 1'b1;
        step();
        chk("rst_mid_valid", 64'(bus_a.inst_valid), 64'd0);
        chk("rst_mid_rd_en", 64'(bus_a.mem_rd_en), 64'd0);
        chk("rst_mid_outputs", 64'({bus_a.inst_opcode, bus_a.inst_operand, bus_a.inst_len, bus_a.inst_pc}), 64'd0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
